// File: rtl/control_cmd_sendrow.sv
// Row serializer: reads one frame-buffer row and streams it out as a row header
// byte followed by every pixel byte, column- and pixel-descending.

package params;
    localparam int BYTES_PER_PIXEL = 2;
    localparam int PIXEL_HEIGHT    = 32;
    localparam int PIXEL_WIDTH     = 16;
endpackage

package calc;
    function automatic int num_row_address_bits(input int height);
        return (height > 1) ? $clog2(height) : 1;
    endfunction

    function automatic int num_column_address_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int num_pixelcolorselect_bits(input int bpp);
        return (bpp > 1) ? $clog2(bpp) : 1;
    endfunction
endpackage

module control_cmd_sendrow #(
    parameter int BYTES_PER_PIXEL = params::BYTES_PER_PIXEL,
    parameter int PIXEL_HEIGHT    = params::PIXEL_HEIGHT,
    parameter int PIXEL_WIDTH     = params::PIXEL_WIDTH,
    parameter int _UNUSED         = 0,
    localparam int R = calc::num_row_address_bits(PIXEL_HEIGHT),
    localparam int C = calc::num_column_address_bits(PIXEL_WIDTH),
    localparam int P = calc::num_pixelcolorselect_bits(BYTES_PER_PIXEL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [R-1:0] row_sel,
    output logic         busy,
    output logic         done,
    output logic [R-1:0] ram_row,
    output logic [C-1:0] ram_column,
    output logic [P-1:0] ram_pixel,
    output logic         ram_read_enable,
    input  logic [7:0]   ram_data_in,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        SEND    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t       state_r;
    state_t       state_n;
    logic [R-1:0] row_r;
    logic [C-1:0] column_r;
    logic [P-1:0] pixel_r;
    logic [7:0]   tx_data_r;
    logic         busy_r;
    logic         done_r;
    logic         tx_valid_r;
    logic         rd_en_r;
    logic         handshake_s;
    logic         last_s;
    logic         unused_param_s;

    assign unused_param_s = (_UNUSED != 0);

    assign handshake_s = tx_valid_r && tx_ready;
    assign last_s      = (column_r == {C{1'b0}}) && (pixel_r == {P{1'b0}});

    assign busy            = busy_r;
    assign done            = done_r;
    assign tx_valid        = tx_valid_r;
    assign tx_data         = tx_data_r;
    assign ram_read_enable = rd_en_r;
    assign ram_row         = row_r;
    assign ram_column      = column_r;
    assign ram_pixel       = pixel_r;

    // Next-state decode for the row transfer sequence
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (start)       state_n = HDR;     else state_n = IDLE;
            HDR:     if (handshake_s) state_n = RD_REQ;  else state_n = HDR;
            RD_REQ:  state_n = RD_WAIT;
            RD_WAIT: state_n = SEND;
            SEND: begin
                if (handshake_s) begin
                    if (last_s) state_n = DONE;
                    else        state_n = RD_REQ;
                end else begin
                    state_n = SEND;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register; status strobes are registered from the next state so they
    // line up exactly with the state they describe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            tx_valid_r <= 1'b0;
            rd_en_r    <= 1'b0;
        end else begin
            state_r    <= state_n;
            busy_r     <= (state_n == HDR) || (state_n == RD_REQ) ||
                          (state_n == RD_WAIT) || (state_n == SEND);
            done_r     <= (state_n == DONE);
            tx_valid_r <= (state_n == HDR) || (state_n == SEND);
            rd_en_r    <= (state_n == RD_REQ);
        end
    end

    // Address counters and transmit byte; all hold while a byte waits for tx_ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_r     <= {R{1'b0}};
            column_r  <= {C{1'b0}};
            pixel_r   <= {P{1'b0}};
            tx_data_r <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        row_r     <= row_sel;
                        column_r  <= C'(PIXEL_WIDTH - 1);
                        pixel_r   <= P'(BYTES_PER_PIXEL - 1);
                        tx_data_r <= 8'(row_sel);
                    end
                end
                RD_WAIT: tx_data_r <= ram_data_in;
                SEND: begin
                    // (0,0) ends the loop before any decrement, so no wrap below zero
                    if (handshake_s && !last_s) begin
                        if (pixel_r == {P{1'b0}}) begin
                            pixel_r  <= P'(BYTES_PER_PIXEL - 1);
                            column_r <= column_r - C'(1);
                        end else begin
                            pixel_r <= pixel_r - P'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_cmd_sendrow.sv
// Self-checking bench for control_cmd_sendrow: table of row transfers with random
// tx_ready stalls, plus hand-written DONE-cycle, back-to-back and reset sequences.

module tb_control_cmd_sendrow;

    localparam int W   = params::PIXEL_WIDTH;
    localparam int BPP = params::BYTES_PER_PIXEL;
    localparam int H   = params::PIXEL_HEIGHT;
    localparam int R   = calc::num_row_address_bits(H);
    localparam int C   = calc::num_column_address_bits(W);
    localparam int P   = calc::num_pixelcolorselect_bits(BPP);
    localparam int LEN = 1 + W * BPP;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [R-1:0] row_sel;
    logic         busy, done;
    logic [R-1:0] ram_row;
    logic [C-1:0] ram_column;
    logic [P-1:0] ram_pixel;
    logic         ram_read_enable;
    logic [7:0]   ram_data_in = 8'h00;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;

    int n_checks = 0;
    int n_pass   = 0;
    int max_stall = 0;
    int stall_left = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int hs_since_re = 0;
    bit stall_prev = 1'b0;
    logic [31:0] held = 32'h0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic [R-1:0] row;
        int           stall;
        bit           poke;
        logic [7:0]   exp_hdr;
        int           exp_len;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    control_cmd_sendrow #(
        .BYTES_PER_PIXEL(BPP), .PIXEL_HEIGHT(H), .PIXEL_WIDTH(W), ._UNUSED(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .row_sel(row_sel),
        .busy(busy), .done(done),
        .ram_row(ram_row), .ram_column(ram_column), .ram_pixel(ram_pixel),
        .ram_read_enable(ram_read_enable), .ram_data_in(ram_data_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    function automatic logic [7:0] ram_byte(input int col, input int pix);
        logic [6:0] c7;
        c7 = col[6:0];
        return {c7, pix[0]};
    endfunction

    function automatic logic [31:0] snap();
        return 32'({busy, done, tx_valid, tx_data, ram_read_enable, ram_row, ram_column, ram_pixel});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference stream: header byte then column-major, pixel-descending data
    task automatic build_exp(input int row);
        exp_q.delete();
        exp_q.push_back(8'(row));
        for (int c = W - 1; c >= 0; c--)
            for (int p = BPP - 1; p >= 0; p--)
                exp_q.push_back(ram_byte(c, p));
    endtask

    task automatic compare_stream(input string name, input int exp_len, input logic [7:0] exp_hdr);
        check({name, "_len"}, got_q.size(), exp_len);
        if (got_q.size() > 0) check({name, "_hdr"}, got_q[0], exp_hdr);
        for (int i = 1; i < exp_q.size(); i++)
            if (i < got_q.size()) check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
    endtask

    // Synchronous frame-buffer model: data appears one cycle after the strobe
    always @(posedge clk) begin
        if (ram_read_enable) ram_data_in <= ram_byte(int'(ram_column), int'(ram_pixel));
    end

    // tx_ready driver: random 0..max_stall stall cycles in front of each byte
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_valid && stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else begin
                tx_ready = 1'b1;
                if (tx_valid) stall_left = $urandom_range(0, max_stall);
            end
        end
    end

    // Stream monitor: captures handshakes and checks stall stability and strobe spacing
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            stall_prev = 1'b0;
            hs_since_re = 0;
        end else begin
            if (stall_prev) check("stall_hold", snap(), held);
            if (ram_read_enable) begin
                check("re_gap", hs_since_re, 1);
                check("re_state", {30'd0, busy, tx_valid}, 32'd2);
                hs_since_re = 0;
            end
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                hs_since_re++;
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check("done_latency", cyc - last_hs_cyc, 1);
                check("done_busy", busy, 0);
                hs_since_re = 0;
            end
            stall_prev = tx_valid && !tx_ready;
            held = snap();
        end
    end

    // Caller is just after a rising edge; start is raised immediately
    task automatic run_xfer(input string name, input logic [R-1:0] row, input int stall,
                            input bit poke, input int linger, input logic [7:0] exp_hdr,
                            input int exp_len);
        int d0;
        int budget;
        max_stall = stall;
        got_q.delete();
        build_exp(int'(row));
        d0 = done_cnt;
        start = 1'b1;
        row_sel = row;
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (done_cnt == d0 && budget < 3000) begin
            row_sel = R'($urandom);
            if (poke && budget == 20) begin
                start = 1'b1;
                row_sel = R'(7);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        check({name, "_timeout"}, budget < 3000, 1);
        repeat (linger) @(posedge clk);
        if (linger > 0) #1;
        check({name, "_done_count"}, done_cnt - d0, 1);
        compare_stream(name, exp_len, exp_hdr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        int d0;
        logic [R-1:0] rr;

        vecs[0] = '{row: R'(5),  stall: 0, poke: 1'b0, exp_hdr: 8'h05, exp_len: LEN};
        vecs[1] = '{row: R'(5),  stall: 5, poke: 1'b0, exp_hdr: 8'h05, exp_len: LEN};
        vecs[2] = '{row: R'(5),  stall: 3, poke: 1'b1, exp_hdr: 8'h05, exp_len: LEN};
        vecs[3] = '{row: R'(31), stall: 2, poke: 1'b0, exp_hdr: 8'h1f, exp_len: LEN};
        for (int i = 4; i < 6; i++) begin
            rr = R'($urandom_range(0, H - 1));
            vecs[i] = '{row: rr, stall: int'($urandom_range(0, 5)), poke: 1'b1,
                        exp_hdr: 8'(rr), exp_len: LEN};
        end

        reset = 1'b0;
        start = 1'b1;
        row_sel = R'(3);
        #1;
        check("reset_outputs", snap(), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold_with_start", snap(), 32'h0);
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_release", snap(), 32'h0);

        for (int i = 0; i < 6; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i].row, vecs[i].stall, vecs[i].poke, 3,
                     vecs[i].exp_hdr, vecs[i].exp_len);
        end

        // start during the DONE cycle is ignored; tx_ready=1 gives exact timing
        max_stall = 0;
        stall_left = 0;
        got_q.delete();
        build_exp(12);
        d0 = done_cnt;
        start = 1'b1;
        row_sel = R'(12);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3 * W * BPP + 1) @(posedge clk);
        #1;
        check("done_cycle_timing", done, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("start_in_done_ignored", {30'd0, busy, tx_valid}, 32'd0);
            @(posedge clk); #1;
        end
        check("done_cycle_count", done_cnt - d0, 1);
        compare_stream("done_cycle", LEN, 8'h0c);

        // Back-to-back: second start lands on the cycle after done
        run_xfer("b2b_first", R'(0), 1, 1'b0, 0, 8'h00, LEN);
        run_xfer("b2b_second", R'(H / 2 - 1), 1, 1'b0, 3, 8'(H / 2 - 1), LEN);

        // Reset mid-transfer after byte 10, then a fresh stream
        max_stall = 2;
        got_q.delete();
        start = 1'b1;
        row_sel = R'(9);
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (got_q.size() < 11 && budget < 2000) begin
            @(posedge clk); #1;
            budget++;
        end
        check("abort_reach_byte10", budget < 2000, 1);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        check("abort_outputs", snap(), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        run_xfer("restart", R'(3), 1, 1'b0, 3, 8'h03, LEN);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
